// File: rtl/fb_write_scheduler_if.sv
// Pixel stream from pixel_reconstruct plus the frame-buffer BRAM port A write bus.
// master = stream source / BRAM side, slave = the write scheduler.
interface fb_write_scheduler_if #(
    parameter int FB_SIZE = 16
);
    logic               pixel_valid_in;
    logic [10:0]        hcount_in;
    logic [9:0]         vcount_in;
    logic [15:0]        pixel_data_in;
    logic [FB_SIZE:0]   addra;
    logic [15:0]        dina;
    logic               wea;

    modport master (
        output pixel_valid_in, hcount_in, vcount_in, pixel_data_in,
        input  addra, dina, wea
    );

    modport slave (
        input  pixel_valid_in, hcount_in, vcount_in, pixel_data_in,
        output addra, dina, wea
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// Decimates the 1280x720 camera stream 4:1 into ping-pong 320x180 RGB565 banks,
// swapping the display bank only after a complete, untorn frame.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | single-shot hold, no writes; capture_req arms
// S_ARMED   | waiting for pixel (0,0); that pixel starts the frame
// S_CAPTURE | writing kept pixels; last pixel swaps banks, (0,0) restarts
module fb_write_scheduler #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int FB_W     = 320,
    parameter int FB_H     = 180,
    parameter int FB_SIZE  = 16
) (
    input  logic                clk_camera,
    input  logic                sys_rst_camera_n,
    fb_write_scheduler_if.slave fb,
    input  logic                pattern_enable,
    input  logic                single_shot,
    input  logic                capture_req,
    output logic                bank_rd,
    output logic                frame_done,
    output logic                busy
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_t;

    localparam logic [FB_SIZE-1:0] LAST_OFF = FB_SIZE'(FB_W * FB_H - 1);

    state_t             state, state_nx;
    logic               bank_wr;
    logic [9:0]         vcount_prev;
    logic [8:0]         px_x;
    logic [7:0]         px_y;
    logic [FB_SIZE-1:0] px_off;
    logic               keep_px, at_origin, v_drop;
    logic               do_write, do_last;
    logic [15:0]        bar_colour;

    assign px_x = fb.hcount_in[10:2];
    assign px_y = fb.vcount_in[9:2];
    // y*320 as y*256 + y*64
    assign px_off = FB_SIZE'({px_y, 8'd0}) + FB_SIZE'({px_y, 6'd0}) + FB_SIZE'(px_x);

    assign keep_px   = fb.pixel_valid_in && (fb.hcount_in[1:0] == 2'b00) &&
                       (fb.vcount_in[1:0] == 2'b00) &&
                       (fb.hcount_in < 11'(H_ACTIVE)) && (fb.vcount_in < 10'(V_ACTIVE));
    assign at_origin = fb.pixel_valid_in && (fb.hcount_in == '0) && (fb.vcount_in == '0);
    // A backwards jump in line number means the camera restarted mid-frame
    assign v_drop    = fb.pixel_valid_in && (fb.vcount_in < vcount_prev) && (fb.vcount_in != '0);

    always_comb begin
        bar_colour = 16'h0000;
        if      (px_x < 9'd40)  bar_colour = 16'hFFFF;
        else if (px_x < 9'd80)  bar_colour = 16'hFFE0;
        else if (px_x < 9'd120) bar_colour = 16'h07FF;
        else if (px_x < 9'd160) bar_colour = 16'h07E0;
        else if (px_x < 9'd200) bar_colour = 16'hF81F;
        else if (px_x < 9'd240) bar_colour = 16'hF800;
        else if (px_x < 9'd280) bar_colour = 16'h001F;
        else                    bar_colour = 16'h0000;
    end

    always_ff @(posedge clk_camera or negedge sys_rst_camera_n) begin
        if (!sys_rst_camera_n) state <= single_shot ? S_IDLE : S_ARMED;
        else                   state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (capture_req) state_nx = S_ARMED;
            S_ARMED:   if (at_origin)   state_nx = S_CAPTURE;
            S_CAPTURE: begin
                if (v_drop)
                    state_nx = S_ARMED;
                else if (keep_px && (px_off == LAST_OFF))
                    state_nx = single_shot ? S_IDLE : S_ARMED;
            end
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        do_write = 1'b0;
        do_last  = 1'b0;
        busy     = 1'b0;
        case (state)
            S_ARMED: begin
                busy     = 1'b1;
                do_write = at_origin;
            end
            S_CAPTURE: begin
                busy     = 1'b1;
                do_write = keep_px && !v_drop;
                do_last  = keep_px && !v_drop && (px_off == LAST_OFF);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_camera or negedge sys_rst_camera_n) begin
        if (!sys_rst_camera_n) begin
            fb.addra    <= '0;
            fb.dina     <= '0;
            fb.wea      <= 1'b0;
            frame_done  <= 1'b0;
            bank_rd     <= 1'b1;
            bank_wr     <= 1'b0;
            vcount_prev <= '0;
        end else begin
            fb.wea     <= do_write;
            frame_done <= do_last;
            if (fb.pixel_valid_in) vcount_prev <= fb.vcount_in;
            if (do_write) begin
                fb.addra <= {bank_wr, px_off};
                fb.dina  <= pattern_enable ? bar_colour : fb.pixel_data_in;
            end
            // Last write still targets the old bank; the swap lands with it
            if (do_last) begin
                bank_rd <= bank_wr;
                bank_wr <= ~bank_wr;
            end
        end
    end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler: full-frame decimation, bank swap,
// colour bars, restart handling, async reset and single-shot capture.
module tb_fb_write_scheduler;
    logic clk_camera = 1'b0;
    logic sys_rst_camera_n = 1'b0;
    logic pattern_enable = 1'b0;
    logic single_shot = 1'b0;
    logic capture_req = 1'b0;
    logic bank_rd, frame_done, busy;

    int errors = 0;
    int checks = 0;

    fb_write_scheduler_if #(.FB_SIZE(16)) fb ();

    fb_write_scheduler dut (
        .clk_camera       (clk_camera),
        .sys_rst_camera_n (sys_rst_camera_n),
        .fb               (fb),
        .pattern_enable   (pattern_enable),
        .single_shot      (single_shot),
        .capture_req      (capture_req),
        .bank_rd          (bank_rd),
        .frame_done       (frame_done),
        .busy             (busy)
    );

    always #5 clk_camera = ~clk_camera;

    // Write monitor: counts writes, checks address sequence from mon_base
    logic        mon_clr = 1'b0;
    logic [16:0] mon_base = '0;
    logic [16:0] exp_addr = '0;
    int          wr_cnt = 0, seq_bad = 0, fd_cnt = 0, fd_bad = 0;
    logic [15:0] d321 = '0;

    always @(negedge clk_camera) begin
        if (mon_clr) begin
            wr_cnt   <= 0;
            seq_bad  <= 0;
            fd_cnt   <= 0;
            fd_bad   <= 0;
            exp_addr <= mon_base;
        end else begin
            if (fb.wea === 1'b1) begin
                wr_cnt   <= wr_cnt + 1;
                exp_addr <= exp_addr + 17'd1;
                if (fb.addra !== exp_addr) seq_bad <= seq_bad + 1;
                if (fb.addra == 17'd321) d321 <= fb.dina;
            end
            if (frame_done === 1'b1) begin
                fd_cnt <= fd_cnt + 1;
                if (!(fb.wea === 1'b1 && fb.addra[15:0] == 16'hE0FF)) fd_bad <= fd_bad + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pd(input int h, input int v);
        return {v[9:2], h[9:2]};
    endfunction

    task automatic step(input bit vld, input int h, input int v, input logic [15:0] d);
        @(negedge clk_camera);
        fb.pixel_valid_in = vld;
        fb.hcount_in      = h[10:0];
        fb.vcount_in      = v[9:0];
        fb.pixel_data_in  = d;
    endtask

    task automatic idle();
        @(negedge clk_camera);
        fb.pixel_valid_in = 1'b0;
        #1;
    endtask

    task automatic clr_mon(input logic [16:0] base);
        #1;
        mon_base = base;
        mon_clr  = 1'b1;
        @(negedge clk_camera);
        #1;
        mon_clr  = 1'b0;
    endtask

    initial begin
        int n;
        fb.pixel_valid_in = 1'b0;
        fb.hcount_in      = '0;
        fb.vcount_in      = '0;
        fb.pixel_data_in  = '0;

        // Reset state, continuous mode
        repeat (3) @(negedge clk_camera);
        #1;
        chk("rst_wea", 32'(fb.wea), 32'd0);
        chk("rst_addra", 32'(fb.addra), 32'd0);
        chk("rst_dina", 32'(fb.dina), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_bank_rd", 32'(bank_rd), 32'd1);
        chk("rst_busy_armed", 32'(busy), 32'd1);
        @(negedge clk_camera);
        sys_rst_camera_n = 1'b1;

        // Stream joining mid-frame: nothing written before (0,0)
        clr_mon(17'd0);
        for (int h = 640; h <= 700; h += 4) step(1'b1, h, 360, pd(h, 360));
        idle();
        chk("midframe_no_writes", 32'(wr_cnt), 32'd0);

        // One full frame of kept pixels
        clr_mon(17'd0);
        for (int v = 0; v < 720; v += 4)
            for (int h = 0; h < 1280; h += 4)
                step(1'b1, h, v, pd(h, v));
        idle();
        idle();
        chk("frame_write_count", 32'(wr_cnt), 32'd57600);
        chk("frame_addr_order", 32'(seq_bad), 32'd0);
        chk("frame_done_count", 32'(fd_cnt), 32'd1);
        chk("frame_done_on_last", 32'(fd_bad), 32'd0);
        chk("pixel_4_4_data", 32'(d321), 32'h0101);
        chk("swap_bank_rd", 32'(bank_rd), 32'd0);
        chk("armed_after_frame", 32'(busy), 32'd1);

        // Next frame goes to bank 1
        step(1'b1, 0, 0, 16'h1234);
        idle();
        chk("bank1_wea", 32'(fb.wea), 32'd1);
        chk("bank1_addra", 32'(fb.addra), 32'h10000);
        chk("bank1_dina", 32'(fb.dina), 32'h1234);

        // Colour bars on row 0
        pattern_enable = 1'b1;
        step(1'b1, 4, 0, 16'h1234);
        idle();
        chk("bar_x1_addra", 32'(fb.addra), 32'h10001);
        chk("bar_x1_dina", 32'(fb.dina), 32'hFFFF);
        step(1'b1, 156, 0, 16'h1234);
        idle();
        chk("bar_x39_dina", 32'(fb.dina), 32'hFFFF);
        step(1'b1, 160, 0, 16'h1234);
        idle();
        chk("bar_x40_addra", 32'(fb.addra), 32'h10028);
        chk("bar_x40_dina", 32'(fb.dina), 32'hFFE0);
        step(1'b1, 800, 0, 16'h1234);
        idle();
        chk("bar_x200_dina", 32'(fb.dina), 32'hF800);
        step(1'b1, 1276, 0, 16'h1234);
        idle();
        chk("bar_x319_addra", 32'(fb.addra), 32'h1013F);
        chk("bar_x319_dina", 32'(fb.dina), 32'h0000);
        pattern_enable = 1'b0;

        // Pixels that must be dropped
        step(1'b1, 1, 0, 16'h1111);
        idle();
        chk("drop_h_odd", 32'(fb.wea), 32'd0);
        step(1'b1, 1280, 0, 16'h1111);
        idle();
        chk("drop_h_limit", 32'(fb.wea), 32'd0);
        step(1'b0, 8, 0, 16'h1111);
        idle();
        chk("drop_not_valid", 32'(fb.wea), 32'd0);

        // Restart at (0,0) after 1000 writes
        clr_mon(17'h10000);
        n = 0;
        for (int v = 0; v <= 12; v += 4)
            for (int h = 0; h < 1280; h += 4)
                if (n < 1000) begin
                    step(1'b1, h, v, pd(h, v));
                    n++;
                end
        idle();
        chk("restart_pre_count", 32'(wr_cnt), 32'd1000);
        chk("restart_pre_order", 32'(seq_bad), 32'd0);
        step(1'b1, 0, 0, 16'h5A5A);
        idle();
        chk("restart_wea", 32'(fb.wea), 32'd1);
        chk("restart_addra", 32'(fb.addra), 32'h10000);
        chk("restart_dina", 32'(fb.dina), 32'h5A5A);
        chk("restart_no_fd", 32'(fd_cnt), 32'd0);
        chk("restart_bank_rd", 32'(bank_rd), 32'd0);

        // Line number jumping backwards aborts to ARMED without a write
        step(1'b1, 0, 8, 16'h2222);
        idle();
        chk("row2_addra", 32'(fb.addra), 32'h10280);
        step(1'b1, 0, 4, 16'h3333);
        idle();
        chk("vdrop_no_write", 32'(fb.wea), 32'd0);
        step(1'b1, 4, 8, 16'h4444);
        idle();
        chk("armed_no_write", 32'(fb.wea), 32'd0);
        step(1'b1, 0, 0, 16'h6666);
        idle();
        chk("rearm_origin_addra", 32'(fb.addra), 32'h10000);

        // Async reset mid-capture
        step(1'b1, 4, 0, 16'h7777);
        @(negedge clk_camera);
        fb.pixel_valid_in = 1'b0;
        #1;
        chk("pre_reset_wea", 32'(fb.wea), 32'd1);
        #2;
        sys_rst_camera_n = 1'b0;
        #1;
        chk("async_rst_wea", 32'(fb.wea), 32'd0);
        chk("async_rst_addra", 32'(fb.addra), 32'd0);
        chk("async_rst_dina", 32'(fb.dina), 32'd0);
        chk("async_rst_bank_rd", 32'(bank_rd), 32'd1);

        // Single-shot mode
        single_shot = 1'b1;
        repeat (2) @(negedge clk_camera);
        #1;
        chk("ss_rst_idle", 32'(busy), 32'd0);
        sys_rst_camera_n = 1'b1;
        clr_mon(17'd0);
        step(1'b1, 0, 0, 16'h0001);
        step(1'b1, 4, 0, 16'h0002);
        step(1'b1, 1276, 716, 16'h0003);
        step(1'b1, 0, 0, 16'h0004);
        step(1'b1, 1276, 716, 16'h0005);
        idle();
        chk("ss_idle_no_writes", 32'(wr_cnt), 32'd0);
        chk("ss_idle_busy", 32'(busy), 32'd0);
        @(negedge clk_camera);
        capture_req = 1'b1;
        @(negedge clk_camera);
        capture_req = 1'b0;
        #1;
        chk("ss_armed_busy", 32'(busy), 32'd1);
        step(1'b1, 0, 0, 16'h1111);
        idle();
        chk("ss_first_addra", 32'(fb.addra), 32'h00000);
        step(1'b1, 4, 0, 16'h2222);
        step(1'b1, 1276, 716, 16'hBEEF);
        idle();
        chk("ss_last_wea", 32'(fb.wea), 32'd1);
        chk("ss_last_addra", 32'(fb.addra), 32'h0E0FF);
        chk("ss_last_dina", 32'(fb.dina), 32'hBEEF);
        chk("ss_last_fd", 32'(frame_done), 32'd1);
        idle();
        chk("ss_fd_pulse_end", 32'(frame_done), 32'd0);
        chk("ss_done_busy", 32'(busy), 32'd0);
        chk("ss_bank_rd", 32'(bank_rd), 32'd0);
        step(1'b1, 0, 0, 16'h3333);
        idle();
        chk("ss_hold_no_write", 32'(fb.wea), 32'd0);
        chk("ss_write_count", 32'(wr_cnt), 32'd3);
        chk("ss_fd_count", 32'(fd_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
